// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter: parity modes, FSM states
// and the frame-length calculation used by both design and verification.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    RSVD = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Total pclk cycles of one frame, start bit through final stop bit.
  function automatic int unsigned frame_cycles(input int unsigned div,
                                               input int unsigned data_width,
                                               input logic [1:0]  parity,
                                               input logic        stop2);
    int unsigned bits;
    bits = 1 + data_width + (stop2 ? 2 : 1);
    if (parity_e'(parity) == EVEN || parity_e'(parity) == ODD) begin
      bits = bits + 1;
    end
    return (div + 1) * bits;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock write buffer for the UART transmitter; registered full/empty
// flags and occupancy, first-word-fall-through read data.
module uart_tx_sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 do_push, do_pop;

  // Requests are qualified here so a push when full or pop when empty is a no-op.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_WIDTH'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge pclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: write FIFO feeding a frame FSM with per-frame latched
// baud divisor, parity mode and stop-bit count. Serial output is registered.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  cfg_en,
  input  logic [DIV_WIDTH-1:0]  cfg_baud_div,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [CNT_WIDTH-1:0]  fifo_count
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  parity_e               mode_q, mode_d;
  logic                  stop2_q, stop2_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  can_start;
  logic                  period_end;
  logic                  launch;

  uart_tx_sync_fifo #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .pclk    (pclk),
    .areset  (areset),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign wr_ready = !fifo_full;

  // Next-state: each state lasts div_q+1 cycles; a bit period ends when cnt_q hits 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    fifo_pop   = 1'b0;
    launch     = 1'b0;
    can_start  = cfg_en && !fifo_empty;
    period_end = (cnt_q == '0);

    if (state_q == IDLE) begin
      launch = can_start;
    end else if (!period_end) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end else begin
      cnt_d = div_q;
      unique case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (mode_q == EVEN || mode_q == ODD) ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
        PARITY: begin
          state_d = STOP;
          bit_d   = '0;
        end
        STOP: begin
          if (stop2_q && bit_q == '0) begin
            bit_d = BIT_W'(1);
          end else if (can_start) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Frame launch latches payload and config so mid-frame changes are ignored.
    if (launch) begin
      fifo_pop = 1'b1;
      state_d  = START;
      cnt_d    = cfg_baud_div;
      div_d    = cfg_baud_div;
      bit_d    = '0;
      shift_d  = fifo_rd_data;
      mode_d   = parity_e'(cfg_parity);
      stop2_d  = cfg_stop2;
      par_d    = (^fifo_rd_data) ^ (cfg_parity == 2'd2);
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == '0) && (!stop2_d || bit_d == BIT_W'(1));
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mode_q  <= NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed waveforms and timings.
module tb_uart_tx_core;
  import uart_tx_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIVW  = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            pclk;
  logic            areset;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_data;
  logic            cfg_en;
  logic [DIVW-1:0] cfg_baud_div;
  logic [1:0]      cfg_parity;
  logic            cfg_stop2;
  logic            tx;
  logic            busy;
  logic            tx_done;
  logic [CW-1:0]   fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_core #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DIVW),
    .CNT_WIDTH  (CW)
  ) dut (
    .pclk         (pclk),
    .areset       (areset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .cfg_en       (cfg_en),
    .cfg_baud_div (cfg_baud_div),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done),
    .fifo_count   (fifo_count)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending payloads and the current frame as a bit list.
  logic [DW-1:0] m_q[$];
  bit            m_busy = 1'b0;
  int unsigned   m_off  = 0;
  int unsigned   m_per  = 1;
  int unsigned   m_nbits = 0;
  int unsigned   m_len  = 0;
  bit            m_bits[16];

  task automatic m_build(input logic [DW-1:0] d);
    int unsigned n;
    n = 0;
    m_bits[n] = 1'b0;
    n++;
    for (int i = 0; i < DW; i++) begin
      m_bits[n] = d[i];
      n++;
    end
    if (cfg_parity == 2'd1 || cfg_parity == 2'd2) begin
      m_bits[n] = (^d) ^ (cfg_parity == 2'd2);
      n++;
    end
    m_bits[n] = 1'b1;
    n++;
    if (cfg_stop2) begin
      m_bits[n] = 1'b1;
      n++;
    end
    m_nbits = n;
    m_per   = int'(cfg_baud_div) + 1;
    m_len   = m_per * m_nbits;
    m_off   = 0;
    m_busy  = 1'b1;
    chk("frame_len", 64'(m_len), 64'(frame_cycles(int'(cfg_baud_div), DW, cfg_parity, cfg_stop2)));
  endtask

  always @(posedge pclk or negedge areset) begin
    int            old_size;
    bit            start_now;
    logic [DW-1:0] d;
    if (!areset) begin
      m_q.delete();
      m_busy = 1'b0;
      m_off  = 0;
    end else begin
      old_size  = m_q.size();
      start_now = 1'b0;
      if (!m_busy) begin
        start_now = cfg_en && old_size > 0;
      end else if (m_off == m_len - 1) begin
        m_busy    = 1'b0;
        start_now = cfg_en && old_size > 0;
      end else begin
        m_off++;
      end
      if (start_now) begin
        d = m_q.pop_front();
        m_build(d);
      end
      if (wr_valid && old_size < int'(DEPTH)) begin
        m_q.push_back(wr_data);
      end
    end
  end

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge pclk) begin
    bit exp_tx;
    exp_tx = m_busy ? m_bits[m_off / m_per] : 1'b1;
    chk("tx",         64'(tx),         64'(exp_tx));
    chk("busy",       64'(busy),       64'(m_busy));
    chk("tx_done",    64'(tx_done),    64'(m_busy && m_off == m_len - 1));
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("wr_ready",   64'(wr_ready),   64'(m_q.size() < int'(DEPTH)));
  end

  logic [63:0] cap_tx;
  logic [63:0] cap_done;
  int          cap_busy;

  task automatic capture(input int n, input bit now);
    cap_tx   = '0;
    cap_done = '0;
    cap_busy = 0;
    for (int k = 1; k <= n; k++) begin
      if (!(now && k == 1)) @(negedge pclk);
      cap_tx   = {cap_tx[62:0], tx};
      cap_done = {cap_done[62:0], tx_done};
      cap_busy += int'(busy);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    @(negedge pclk);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge pclk);
    wr_valid = 1'b0;
  endtask

  task automatic send2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge pclk);
    wr_valid = 1'b1;
    wr_data  = a;
    @(negedge pclk);
    wr_data  = b;
    @(negedge pclk);
    wr_valid = 1'b0;
  endtask

  task automatic set_cfg(input int div, input logic [1:0] par, input logic s2);
    cfg_baud_div = DIVW'(div);
    cfg_parity   = par;
    cfg_stop2    = s2;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge pclk);
      if (!busy && fifo_count == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rx_byte;
    bit            found;
    int            t;
    int            first_done;
    int            second_done;

    areset   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    cfg_en   = 1'b1;
    set_cfg(3, 2'd0, 1'b0);
    repeat (3) @(negedge pclk);
    chk("rst_tx",       64'(tx),         64'd1);
    chk("rst_busy",     64'(busy),       64'd0);
    chk("rst_count",    64'(fifo_count), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready),   64'd1);
    #2 areset = 1'b1;
    repeat (2) @(negedge pclk);

    // 8N1, div=3, 0xA5
    set_cfg(3, 2'd0, 1'b0);
    send(8'hA5);
    capture(44, 1'b0);
    chk("a5_wave", cap_tx,   64'h0F0F00F0FFF);
    chk("a5_done", cap_done, 64'h10);
    chk("a5_busy", 64'(cap_busy), 64'd40);

    // even / odd / reserved parity
    set_cfg(1, 2'd1, 1'b0);
    send(8'h07);
    capture(24, 1'b0);
    chk("even_wave", cap_tx,   64'h3F003F);
    chk("even_done", cap_done, 64'h4);
    chk("even_busy", 64'(cap_busy), 64'd22);
    set_cfg(1, 2'd2, 1'b0);
    send(8'h07);
    capture(24, 1'b0);
    chk("odd_wave", cap_tx, 64'h3F000F);
    chk("odd_busy", 64'(cap_busy), 64'd22);
    set_cfg(0, 2'd3, 1'b0);
    send(8'h07);
    capture(12, 1'b0);
    chk("rsvd_wave", cap_tx,   64'h707);
    chk("rsvd_done", cap_done, 64'h4);
    chk("rsvd_busy", 64'(cap_busy), 64'd10);

    // two stop bits, div=0, back-to-back frames
    set_cfg(0, 2'd0, 1'b1);
    send2(8'h00, 8'hFF);
    capture(24, 1'b1);
    chk("b2b_wave", cap_tx,   64'h006FFF);
    chk("b2b_done", cap_done, 64'h2004);
    chk("b2b_busy", 64'(cap_busy), 64'd22);

    // fill with cfg_en low, ninth write dropped, then drain in order
    cfg_en = 1'b0;
    set_cfg(0, 2'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge pclk);
      wr_valid = 1'b1;
      wr_data  = DW'(i);
    end
    @(negedge pclk);
    wr_valid = 1'b0;
    chk("full_ready", 64'(wr_ready),   64'd0);
    chk("full_count", 64'(fifo_count), 64'd8);
    cfg_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      found = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge pclk);
        if (tx == 1'b0) begin
          found = 1'b1;
          break;
        end
      end
      chk("drain_start", 64'(found), 64'd1);
      for (int b = 0; b < DW; b++) begin
        @(negedge pclk);
        rx_byte[b] = tx;
      end
      chk("drain_byte", 64'(rx_byte), 64'(f + 1));
      @(negedge pclk);
      chk("drain_stop", 64'(tx), 64'd1);
    end
    wait_idle(20);

    // async reset during data bit 3 with two entries queued
    set_cfg(3, 2'd0, 1'b0);
    @(negedge pclk);
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    @(negedge pclk);
    wr_data  = 8'h22;
    @(negedge pclk);
    wr_data  = 8'h33;
    @(negedge pclk);
    wr_valid = 1'b0;
    repeat (16) @(negedge pclk);
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    #2 areset = 1'b0;
    #1;
    chk("mid_rst_tx",    64'(tx),         64'd1);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_busy",  64'(busy),       64'd0);
    chk("mid_rst_ready", 64'(wr_ready),   64'd1);
    @(negedge pclk);
    #2 areset = 1'b1;
    capture(30, 1'b0);
    chk("post_rst_busy", 64'(cap_busy), 64'd0);

    // divisor change mid-frame applies to the next frame only
    set_cfg(3, 2'd0, 1'b0);
    send2(8'h3C, 8'hC3);
    t           = 1;
    first_done  = 0;
    second_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      t++;
      if (t == 6) cfg_baud_div = DIVW'(7);
      if (tx_done) begin
        if (first_done == 0) first_done = t;
        else begin
          second_done = t;
          break;
        end
      end
    end
    chk("div_first_done",  64'(first_done),  64'd40);
    chk("div_second_done", 64'(second_done), 64'd120);
    wait_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Parametrised, synthesizable UART transmitter with a write FIFO, runtime baud divisor, parity mode and stop-bit count. It is the first DUT-side block to sit between the tx and rx agent BFMs in the top-level bench: it is driven by the bench clock/reset, and its serial output feeds the interface line the rx BFM samples. It generalises fixed 8N1 operation to any data width, depth and frame format.

Parameters:
DATA_WIDTH, 8, payload bits per frame, legal range 5..9
FIFO_DEPTH, 8, write-buffer entries, power of two >= 2
DIV_WIDTH, 16, width of baud divisor input
CNT_WIDTH, $clog2(FIFO_DEPTH+1), derived width of the occupancy count

Ports:
pclk  input  1  system clock; all state on rising edge
areset  input  1  asynchronous, active-low reset
wr_valid  input  1  write request
wr_ready  output  1  FIFO can accept; high when count < FIFO_DEPTH
wr_data  input  DATA_WIDTH  payload, LSB transmitted first
cfg_en  input  1  allows new frames to start
cfg_baud_div  input  DIV_WIDTH  bit period = cfg_baud_div+1 pclk cycles
cfg_parity  input  2  0 none, 1 even, 2 odd, 3 reserved (= none)
cfg_stop2  input  1  0: one stop bit, 1: two stop bits
tx  output  1  serial line, idle high
busy  output  1  high from START entry to STOP exit
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit
fifo_count  output  CNT_WIDTH  current occupancy

Behaviour:
- Reset (areset=0, any time, including mid-frame): tx=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1, FSM=IDLE, FIFO contents discarded, bit/baud counters cleared.
- Write handshake: an entry is accepted on the edge where wr_valid && wr_ready. wr_ready depends only on the count, not on a same-cycle pop. A write when full is ignored, with no side effects.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or straight to START when back-to-back frames are allowed.
- IDLE: if cfg_en && count>0, pop the head, latch the payload plus cfg_baud_div/cfg_parity/cfg_stop2 into frame registers, and enter START. Config changes mid-frame have no effect on the current frame.
- Each state holds for (latched div+1) cycles, timed by a down-counter reloaded on state or bit change.
- START: tx=0.
- DATA: DATA_WIDTH bits, LSB first.
- PARITY: entered only for modes 1 and 2. Even mode sends the XOR of the payload; odd mode sends its inverse.
- STOP: tx=1 for 1 or 2 bit periods. On the last cycle, pulse tx_done. Then pop the next entry if cfg_en && count>0 (no idle gap), else go to IDLE.
- Latency: a write accepted at edge N into an empty FIFO with FSM idle and cfg_en=1 drives tx low after edge N+1.
- Frame length in cycles = (div+1) * (1 + DATA_WIDTH + parity_bit + stop_bits).
- Simultaneous push and pop: the count is unchanged and the data order is preserved. Pointers wrap modulo FIFO_DEPTH.
- cfg_en deasserted mid-frame: the current frame completes and no new frame starts. The FIFO keeps accepting writes.
- cfg_baud_div=0: one cycle per bit, with no counter underflow.
- tx is a registered output and glitch-free.

Decomposition:
- uart_tx_pkg holds:
  - the parity mode enum (NONE, EVEN, ODD, RSVD)
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - the frame-length helper function, which the verification team also uses
- Sub-module uart_tx_sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/count; same pclk/areset) holds the storage and pointers. uart_tx_core keeps the FSM, baud counter and shifter.

Test Plan:
- 8N1, div=3, write 0xA5 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop 4 cycles. Frame is 40 cycles; tx_done pulses at cycle 40.
- Even parity, div=1, write 0x07 -> parity bit 1, frame 22 cycles. Repeat with odd parity -> parity bit 0.
- cfg_stop2=1, div=0, write 0x00 then 0xFF back-to-back -> two 11-cycle frames, no idle gap, second start bit right after the second stop cycle.
- cfg_en=0, write 9 entries with FIFO_DEPTH=8 -> 8 accepted, wr_ready=0, fifo_count=8, 9th dropped. Set cfg_en=1 -> 8 frames sent in order, fifo_count reaches 0.
- areset pulsed low during the DATA bit 3 of a frame with 2 entries queued -> tx=1 and fifo_count=0 immediately. After release, no frame until a new write.
- Change cfg_baud_div from 3 to 7 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8-cycle bits.
